// File: rtl/usb_pkg.sv
// Shared USB-core definitions: buffer sizing and occupancy type used by
// data_buffer, usb_rx and the AHB slave.
package usb_pkg;

    localparam int unsigned DEPTH_DEF = 64;
    localparam int unsigned PTR_W     = $clog2(DEPTH_DEF);
    localparam int unsigned OCC_W     = 7;

    typedef logic [OCC_W-1:0] occ_t;
    typedef logic [7:0]       byte_t;

    // Which access port supplies the byte for an accepted write.
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_RX   = 2'b01,
        SRC_TX   = 2'b10
    } wr_src_e;

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port.
// Contents have no reset; only the pointers in data_buffer give them meaning.
module buffer_ram
    import usb_pkg::*;
#(
    parameter int unsigned ADDR_W = PTR_W,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_buffer.sv
// Circular byte FIFO shared by the USB receiver/transmitter and the AHB slave,
// with show-ahead head outputs and a registered error pulse.
module data_buffer
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             get_tx_packet_data,
    input  logic             flush,
    input  logic             clear,
    output logic [7:0]       rx_data,
    output logic [7:0]       tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buffer_error
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wptr, rptr;
    occ_t          occ;
    logic          err;
    wr_src_e       wr_src;
    byte_t         wr_byte, head;
    logic          wr_req, pop_req, empty, full;
    logic          pop_ok, wr_ok, empty_req, err_next;

    always_comb begin
        wr_src = SRC_NONE;
        if (store_rx_packet_data) begin
            wr_src = SRC_RX;
        end else if (store_tx_data) begin
            wr_src = SRC_TX;
        end
    end

    assign wr_byte   = (wr_src == SRC_TX) ? tx_data : rx_packet_data;
    assign wr_req    = (wr_src != SRC_NONE);
    assign pop_req   = get_rx_data | get_tx_packet_data;
    assign empty     = (occ == '0);
    assign full      = (occ == occ_t'(DEPTH));
    assign empty_req = flush | clear;

    // A pop on an empty buffer never sees the same-cycle write; a write at full
    // is admitted only when a real pop frees the slot.
    assign pop_ok = pop_req & ~empty;
    assign wr_ok  = wr_req & (~full | pop_ok);

    assign err_next = ~empty_req & ((store_rx_packet_data & store_tx_data)
                                  | (wr_req & ~wr_ok)
                                  | (pop_req & empty));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            err  <= 1'b0;
        end else if (empty_req) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            err  <= 1'b0;
        end else begin
            err <= err_next;
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            if (wr_ok && !pop_ok) begin
                occ <= occ + occ_t'(1);
            end else if (pop_ok && !wr_ok) begin
                occ <= occ - occ_t'(1);
            end
        end
    end

    buffer_ram #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~empty_req),
        .waddr (wptr),
        .wdata (wr_byte),
        .raddr (rptr),
        .rdata (head)
    );

    assign rx_data          = empty ? 8'h00 : head;
    assign tx_packet_data   = rx_data;
    assign buffer_occupancy = occ;
    assign buffer_error     = err;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points.
module tb_data_buffer;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       srx = 1'b0, stx = 1'b0, grx = 1'b0, gtx = 1'b0, fl = 1'b0, cl = 1'b0;
    logic [7:0] rxd = '0, txd = '0;
    logic [7:0] rx_data, tx_packet_data;
    logic [6:0] occ;
    logic       berr;

    int checks = 0;
    int errors = 0;

    data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_rx_packet_data (srx),
        .rx_packet_data       (rxd),
        .store_tx_data        (stx),
        .tx_data              (txd),
        .get_rx_data          (grx),
        .get_tx_packet_data   (gtx),
        .flush                (fl),
        .clear                (cl),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (occ),
        .buffer_error         (berr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue updated from the rules on every edge.
    logic [7:0] q[$];
    logic       m_err = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            m_err = 1'b0;
        end else if (fl || cl) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            automatic logic       wreq  = srx || stx;
            automatic logic       preq  = grx || gtx;
            automatic logic [7:0] wb    = srx ? rxd : txd;
            automatic logic       popok = preq && (q.size() > 0);
            automatic logic       wok   = wreq && ((q.size() < DEPTH) || popok);
            m_err = (srx && stx) || (wreq && !wok) || (preq && q.size() == 0);
            if (popok) void'(q.pop_front());
            if (wok) q.push_back(wb);
        end
    end

    always @(negedge clk) begin
        automatic logic [7:0] mh = (q.size() > 0) ? q[0] : 8'h00;
        chk("model_occ", 32'(occ), 32'(q.size()));
        chk("model_rx_data", 32'(rx_data), 32'(mh));
        chk("model_tx_packet_data", 32'(tx_packet_data), 32'(mh));
        chk("model_err", 32'(berr), 32'(m_err));
    end

    // Called at posedge+2; applies inputs across one edge, returns at posedge+2.
    task automatic step(input logic s_rx, input logic [7:0] d_rx,
                        input logic s_tx, input logic [7:0] d_tx,
                        input logic g_rx, input logic g_tx,
                        input logic f, input logic c);
        srx = s_rx; rxd = d_rx; stx = s_tx; txd = d_tx;
        grx = g_rx; gtx = g_tx; fl = f; cl = c;
        @(posedge clk);
        #2;
        srx = 0; stx = 0; grx = 0; gtx = 0; fl = 0; cl = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1, d, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic pop();
        step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    endtask

    initial begin
        #12;
        chk("reset_occ", 32'(occ), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        chk("reset_err", 32'(berr), 0);
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #2;

        // Single byte through
        wr(8'hA5);
        chk("single_occ", 32'(occ), 1);
        chk("single_rx", 32'(rx_data), 32'hA5);
        chk("single_tx", 32'(tx_packet_data), 32'hA5);
        pop();
        chk("single_pop_occ", 32'(occ), 0);
        chk("single_pop_rx", 32'(rx_data), 0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 64; i++) wr(8'(i));
        wr(8'hFF);
        chk("full_occ", 32'(occ), 64);
        chk("overflow_err", 32'(berr), 1);
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("overflow_err_one_cycle", 32'(berr), 0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_order", 32'(rx_data), 32'(i));
            pop();
        end
        chk("drained_occ", 32'(occ), 0);

        // Pop on empty
        pop();
        chk("underflow_err", 32'(berr), 1);

        // Write and pop at full
        for (int i = 0; i < 64; i++) wr(8'(8'h40 + i));
        step(1, 8'h77, 0, 8'h00, 1, 0, 0, 0);
        chk("full_wr_pop_occ", 32'(occ), 64);
        chk("full_wr_pop_err", 32'(berr), 0);
        chk("full_wr_pop_head", 32'(rx_data), 32'h41);
        for (int i = 0; i < 63; i++) pop();
        chk("wrap_head_77", 32'(rx_data), 32'h77);
        pop();
        chk("wrap_occ", 32'(occ), 0);

        // Flush overrides write and pop
        for (int i = 0; i < 10; i++) wr(8'(8'h80 + i));
        chk("pre_flush_occ", 32'(occ), 10);
        step(1, 8'h99, 0, 8'h00, 1, 0, 1, 0);
        chk("flush_occ", 32'(occ), 0);
        chk("flush_err", 32'(berr), 0);
        chk("flush_rx", 32'(rx_data), 0);
        wr(8'h3C);
        chk("post_flush_head", 32'(rx_data), 32'h3C);
        pop();

        // Dual write strobes plus pop on empty
        step(1, 8'h11, 1, 8'h22, 1, 0, 0, 0);
        chk("dual_wr_occ", 32'(occ), 1);
        chk("dual_wr_head", 32'(rx_data), 32'h11);
        chk("dual_wr_err", 32'(berr), 1);

        // Both pop strobes pop a single byte; tx-side write path
        step(0, 8'h00, 1, 8'h5D, 0, 0, 0, 0);
        step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
        chk("dual_pop_occ", 32'(occ), 1);
        chk("dual_pop_head", 32'(rx_data), 32'h5D);

        // Clear held as a level for two cycles
        step(1, 8'h01, 0, 8'h00, 0, 0, 0, 1);
        step(1, 8'h02, 0, 8'h00, 0, 1, 0, 1);
        chk("clear_occ", 32'(occ), 0);
        chk("clear_err", 32'(berr), 0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        chk("pre_rst_occ", 32'(occ), 5);
        #1;
        n_rst = 1'b0;
        #1;
        chk("async_rst_occ", 32'(occ), 0);
        chk("async_rst_rx", 32'(rx_data), 0);
        chk("async_rst_tx", 32'(tx_packet_data), 0);
        chk("async_rst_err", 32'(berr), 0);
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        wr(8'h5A);
        chk("post_rst_head", 32'(rx_data), 32'h5A);
        chk("post_rst_occ", 32'(occ), 1);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_buffer.md
DATA_BUFFER -- requirements
Module: data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, byte capacity (power of two).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port store_rx_packet_data  input  1  receiver write strobe, one byte per cycle high.
REQ-005 SHALL have port rx_packet_data  input  8  receiver write byte.
REQ-006 SHALL have port store_tx_data  input  1  AHB-side write strobe (host loads transmit payload).
REQ-007 SHALL have port tx_data  input  8  AHB-side write byte.
REQ-008 SHALL have port get_rx_data  input  1  AHB-side pop strobe.
REQ-009 SHALL have port get_tx_packet_data  input  1  transmitter pop strobe.
REQ-010 SHALL have port flush  input  1  receiver empty request, one cycle or level.
REQ-011 SHALL have port clear  input  1  AHB-side empty request.
REQ-012 SHALL have port rx_data  output  8  head byte for AHB side.
REQ-013 SHALL have port tx_packet_data  output  8  head byte for transmitter (same value as rx_data).
REQ-014 SHALL have port buffer_occupancy  output  7  bytes stored, 0..DEPTH.
REQ-015 SHALL have port buffer_error  output  1  one-cycle pulse on rejected write or pop.

Function
REQ-016 SHALL implement a circular FIFO: write pointer, read pointer (log2(DEPTH) bits each, wrap DEPTH-1 -> 0), occupancy counter.
REQ-017 Write request = store_rx_packet_data OR store_tx_data; when both high, rx_packet_data SHALL be written and tx_data dropped, buffer_error pulsed.
REQ-018 Pop request = get_rx_data OR get_tx_packet_data; at most one byte SHALL be popped per cycle regardless of both being high.
REQ-019 Head outputs SHALL be show-ahead: rx_data = tx_packet_data = mem[read pointer] when occupancy > 0, 8'h00 when empty; a pop advances the head for the next cycle.
REQ-020 Accepted write SHALL store the byte and increment write pointer and occupancy at the same edge (write latency 1 cycle; byte visible at head next cycle if buffer was empty).
REQ-021 Write with occupancy == DEPTH and no simultaneous accepted pop SHALL be ignored (memory, pointers unchanged) and buffer_error pulsed.
REQ-022 Write at full with simultaneous pop SHALL be accepted; occupancy stays DEPTH.
REQ-023 Pop with occupancy == 0 SHALL be ignored and buffer_error pulsed, even if a write occurs the same cycle (no write-through bypass); the write is still accepted.
REQ-024 Simultaneous accepted write and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-025 flush OR clear high SHALL, at that edge, zero both pointers and occupancy, override any same-cycle write or pop, and not pulse buffer_error.
REQ-026 Memory contents SHALL NOT be cleared by flush/clear; only pointers reset.
REQ-027 buffer_occupancy SHALL be a registered output, never exceeding DEPTH.
REQ-028 buffer_error SHALL be registered, high exactly one cycle after the offending request.

Reset
REQ-029 n_rst low SHALL asynchronously set pointers 0, buffer_occupancy 0, buffer_error 0, hence rx_data = tx_packet_data = 8'h00.
REQ-030 Reset mid-transfer SHALL discard all stored bytes; first accepted write after release lands in entry 0.

Structure
REQ-031 DEPTH default, pointer width and the 7-bit occupancy type SHALL live in the shared USB package, reused by usb_rx and the AHB slave.
REQ-032 Storage SHALL be a sub-module buffer_ram (DEPTH x 8, one write port, one asynchronous read port); pointer/occupancy control stays in data_buffer.

Verification
REQ-033 Reset, write 8'hA5 via store_rx_packet_data -> next cycle occupancy 1, rx_data 8'hA5; pop -> occupancy 0, rx_data 8'h00.
REQ-034 64 writes 0x00..0x3F then 65th write 0xFF -> occupancy 64, buffer_error one pulse, 64 pops return 0x00..0x3F in order.
REQ-035 At occupancy 64, simultaneous write 0x77 and pop -> occupancy 64, pointers wrap, 0x77 emerges as 64th subsequent pop.
REQ-036 Occupancy 10, flush high together with a write and a pop -> occupancy 0 next cycle, no buffer_error, next write appears at head.
REQ-037 Empty, store_rx_packet_data 0x11 and store_tx_data 0x22 same cycle, plus get_rx_data -> occupancy 1, head 0x11, buffer_error pulsed.
REQ-038 Occupancy 5, assert n_rst low mid-cycle -> outputs zero immediately without clock edge.
